// File: rtl/logic_unit_arbiter_pkg.sv
// Shared definitions for the two-requester logical-unit arbiter:
// operation and buffer-state encodings plus operand/result widths.
package logic_unit_arbiter_pkg;

    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_XOR = 2'b10,
        OP_NOT = 2'b11
    } op_e;

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_e;

    localparam int unsigned OPND_W = 4;
    localparam int unsigned Z_W    = 8;

    // Widen a nibble result to the 8-bit result bus.
    function automatic logic [Z_W-1:0] zext_nibble(input logic [OPND_W-1:0] v);
        return {4'h0, v};
    endfunction

endpackage

// File: rtl/logic_unit_arbiter_if.sv
// Request/response bundle between the requesters, the consumer and the arbiter.
interface logic_unit_arbiter_if #(
    parameter int CNT_W = 8
) ();
    import logic_unit_arbiter_pkg::*;

    logic              req0_valid;
    logic [OPND_W-1:0] req0_x;
    logic [OPND_W-1:0] req0_y;
    logic [1:0]        req0_op;
    logic              req0_ready;
    logic              req1_valid;
    logic [OPND_W-1:0] req1_x;
    logic [OPND_W-1:0] req1_y;
    logic [1:0]        req1_op;
    logic              req1_ready;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [Z_W-1:0]    rsp_z;
    logic              rsp_id;
    logic [CNT_W-1:0]  cnt0;
    logic [CNT_W-1:0]  cnt1;

    modport master (
        output req0_valid, req0_x, req0_y, req0_op,
        output req1_valid, req1_x, req1_y, req1_op,
        output rsp_ready,
        input  req0_ready, req1_ready, rsp_valid, rsp_z, rsp_id, cnt0, cnt1
    );

    modport slave (
        input  req0_valid, req0_x, req0_y, req0_op,
        input  req1_valid, req1_x, req1_y, req1_op,
        input  rsp_ready,
        output req0_ready, req1_ready, rsp_valid, rsp_z, rsp_id, cnt0, cnt1
    );
endinterface

// File: rtl/logic_unit_arbiter_units.sv
// Datapath (logical + eightbitmux) and the two-way round-robin grant used by
// the arbiter top level.
module eightbitmux
    import logic_unit_arbiter_pkg::*;
(
    input  logic [Z_W-1:0] in0,
    input  logic [Z_W-1:0] in1,
    input  logic [Z_W-1:0] in2,
    input  logic [Z_W-1:0] in3,
    input  logic [1:0]     sel,
    output logic [Z_W-1:0] out
);
    // Select one of the four candidate results by operation code.
    always_comb begin
        out = 8'h00;
        case (sel)
            OP_AND:  out = in0;
            OP_OR:   out = in1;
            OP_XOR:  out = in2;
            OP_NOT:  out = in3;
            default: out = 8'h00;
        endcase
    end
endmodule

module logical
    import logic_unit_arbiter_pkg::*;
(
    input  logic [OPND_W-1:0] x,
    input  logic [OPND_W-1:0] y,
    input  logic [1:0]        op,
    output logic [Z_W-1:0]    z
);
    logic [Z_W-1:0] and_s;
    logic [Z_W-1:0] or_s;
    logic [Z_W-1:0] xor_s;
    logic [Z_W-1:0] not_s;

    assign and_s = zext_nibble(x & y);
    assign or_s  = zext_nibble(x | y);
    assign xor_s = zext_nibble(x ^ y);
    assign not_s = ~{y, x};

    eightbitmux u_mux (
        .in0 (and_s),
        .in1 (or_s),
        .in2 (xor_s),
        .in3 (not_s),
        .sel (op),
        .out (z)
    );
endmodule

module rr_arb2 #(
    parameter bit FAIR = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] valid,
    input  logic       accept,
    output logic [1:0] grant
);
    logic last_grant_r;

    // One-hot grant; a tie goes to the requester that did not win last time.
    always_comb begin
        grant = 2'b00;
        case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11: begin
                if (FAIR) begin
                    grant = last_grant_r ? 2'b01 : 2'b10;
                end else begin
                    grant = 2'b01;
                end
            end
            default: grant = 2'b00;
        endcase
    end

    // Remember the winner only when the operation was actually taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_r <= 1'b1;
        end else if (accept) begin
            last_grant_r <= grant[1];
        end else begin
            last_grant_r <= last_grant_r;
        end
    end
endmodule

// File: rtl/logic_unit_arbiter.sv
// Two-requester arbiter around one logical unit with a one-entry registered
// output buffer and per-requester completion counters.
module logic_unit_arbiter
    import logic_unit_arbiter_pkg::*;
#(
    parameter int CNT_W = 8,
    parameter bit FAIR  = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    logic_unit_arbiter_if.slave  bus
);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e            state_r;
    state_e            state_nxt_s;
    logic [1:0]        valid_s;
    logic [1:0]        grant_s;
    logic              can_accept_s;
    logic              accept_s;
    logic              complete_s;
    logic [OPND_W-1:0] x_s;
    logic [OPND_W-1:0] y_s;
    logic [1:0]        op_s;
    logic [Z_W-1:0]    z_s;
    logic [Z_W-1:0]    rsp_z_r;
    logic              rsp_id_r;
    logic [CNT_W-1:0]  cnt0_r;
    logic [CNT_W-1:0]  cnt1_r;

    assign valid_s      = {bus.req1_valid, bus.req0_valid};
    assign can_accept_s = (state_r == S_EMPTY) | bus.rsp_ready;
    assign accept_s     = can_accept_s & (|valid_s);
    assign complete_s   = (state_r == S_FULL) & bus.rsp_ready;

    assign bus.req0_ready = can_accept_s & bus.req0_valid & grant_s[0];
    assign bus.req1_ready = can_accept_s & bus.req1_valid & grant_s[1];
    assign bus.rsp_valid  = (state_r == S_FULL);
    assign bus.rsp_z      = rsp_z_r;
    assign bus.rsp_id     = rsp_id_r;
    assign bus.cnt0       = cnt0_r;
    assign bus.cnt1       = cnt1_r;

    rr_arb2 #(.FAIR(FAIR)) u_arb (
        .clk    (clk),
        .rst_n  (reset_n),
        .valid  (valid_s),
        .accept (accept_s),
        .grant  (grant_s)
    );

    // Operand mux; idle or invalid channels feed zeros so X never reaches z.
    always_comb begin
        x_s  = 4'h0;
        y_s  = 4'h0;
        op_s = 2'b00;
        case (grant_s)
            2'b01: begin
                x_s  = bus.req0_x;
                y_s  = bus.req0_y;
                op_s = bus.req0_op;
            end
            2'b10: begin
                x_s  = bus.req1_x;
                y_s  = bus.req1_y;
                op_s = bus.req1_op;
            end
            default: begin
                x_s  = 4'h0;
                y_s  = 4'h0;
                op_s = 2'b00;
            end
        endcase
    end

    logical u_logical (
        .x  (x_s),
        .y  (y_s),
        .op (op_s),
        .z  (z_s)
    );

    // Buffer occupancy: a new accept refills, a drain without refill empties.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_EMPTY: begin
                if (accept_s) begin
                    state_nxt_s = S_FULL;
                end else begin
                    state_nxt_s = S_EMPTY;
                end
            end
            S_FULL: begin
                if (bus.rsp_ready && !accept_s) begin
                    state_nxt_s = S_EMPTY;
                end else begin
                    state_nxt_s = S_FULL;
                end
            end
            default: state_nxt_s = S_EMPTY;
        endcase
    end

    // Buffer state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= S_EMPTY;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Result buffer captured on the accept edge; held otherwise.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_z_r  <= 8'h00;
            rsp_id_r <= 1'b0;
        end else if (accept_s) begin
            rsp_z_r  <= z_s;
            rsp_id_r <= grant_s[1];
        end else begin
            rsp_z_r  <= rsp_z_r;
            rsp_id_r <= rsp_id_r;
        end
    end

    // Completion counters, wrapping naturally at 2**CNT_W.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt0_r <= {CNT_W{1'b0}};
            cnt1_r <= {CNT_W{1'b0}};
        end else if (complete_s) begin
            cnt0_r <= rsp_id_r ? cnt0_r : cnt0_r + CNT_ONE;
            cnt1_r <= rsp_id_r ? cnt1_r + CNT_ONE : cnt1_r;
        end else begin
            cnt0_r <= cnt0_r;
            cnt1_r <= cnt1_r;
        end
    end
endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Self-checking bench: directed table and sequences plus randomized traffic
// checked against a queue-based model of the arbiter.
module tb_logic_unit_arbiter;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    logic_unit_arbiter_if #(.CNT_W(8)) bus_a ();
    logic_unit_arbiter_if #(.CNT_W(2)) bus_b ();

    logic_unit_arbiter #(.CNT_W(8), .FAIR(1'b1)) dut_a (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_a.slave)
    );

    logic_unit_arbiter #(.CNT_W(2), .FAIR(1'b0)) dut_b (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_b.slave)
    );

    typedef struct {
        logic [7:0] z;
        logic       id;
    } resp_t;

    typedef struct {
        logic [3:0] x;
        logic [3:0] y;
        logic [1:0] op;
        logic [7:0] z;
    } vec_t;

    int    n_pass  = 0;
    int    n_total = 0;
    resp_t mq[$];
    bit    m_last;
    int    m_cnt[2];
    int    w;
    vec_t  vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [7:0] ref_z(input logic [3:0] x, input logic [3:0] y, input logic [1:0] op);
        case (op)
            2'b00:   return {4'h0, x & y};
            2'b01:   return {4'h0, x | y};
            2'b10:   return {4'h0, x ^ y};
            default: return 8'hFF - {y, x};
        endcase
    endfunction

    task automatic model_reset();
        mq.delete();
        m_last   = 1'b1;
        m_cnt[0] = 0;
        m_cnt[1] = 0;
    endtask

    // One clock of dut_a against the model; inputs are already applied.
    task automatic model_cycle(output int win);
        bit can;
        logic [7:0] z0, z1;
        #2;
        z0  = ref_z(bus_a.req0_x, bus_a.req0_y, bus_a.req0_op);
        z1  = ref_z(bus_a.req1_x, bus_a.req1_y, bus_a.req1_op);
        can = (mq.size() == 0) || bus_a.rsp_ready;
        win = -1;
        if (can) begin
            if (bus_a.req0_valid && bus_a.req1_valid) win = m_last ? 0 : 1;
            else if (bus_a.req0_valid) win = 0;
            else if (bus_a.req1_valid) win = 1;
        end
        check("req0_ready", {31'd0, bus_a.req0_ready}, {31'd0, win == 0});
        check("req1_ready", {31'd0, bus_a.req1_ready}, {31'd0, win == 1});
        @(posedge clk);
        if (mq.size() != 0 && bus_a.rsp_ready) begin
            m_cnt[mq[0].id] = (m_cnt[mq[0].id] + 1) % 256;
            void'(mq.pop_front());
        end
        if (win == 0) begin mq.push_back('{z0, 1'b0}); m_last = 1'b0; end
        if (win == 1) begin mq.push_back('{z1, 1'b1}); m_last = 1'b1; end
        #1;
        check("rsp_valid", {31'd0, bus_a.rsp_valid}, {31'd0, mq.size() != 0});
        if (mq.size() != 0) begin
            check("rsp_z", {24'd0, bus_a.rsp_z}, {24'd0, mq[0].z});
            check("rsp_id", {31'd0, bus_a.rsp_id}, {31'd0, mq[0].id});
        end
        check("cnt0", {24'd0, bus_a.cnt0}, m_cnt[0]);
        check("cnt1", {24'd0, bus_a.cnt1}, m_cnt[1]);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_rsp_valid"}, {31'd0, bus_a.rsp_valid}, 32'd0);
        check({tag, "_rsp_z"},     {24'd0, bus_a.rsp_z},     32'd0);
        check({tag, "_rsp_id"},    {31'd0, bus_a.rsp_id},    32'd0);
        check({tag, "_cnt0"},      {24'd0, bus_a.cnt0},      32'd0);
        check({tag, "_cnt1"},      {24'd0, bus_a.cnt1},      32'd0);
        check({tag, "_b_valid"},   {31'd0, bus_b.rsp_valid}, 32'd0);
        check({tag, "_b_cnt1"},    {30'd0, bus_b.cnt1},      32'd0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        check_cleared("reset");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
    endtask

    initial begin
        vecs[0] = '{4'hC, 4'hA, 2'b00, 8'h08};
        vecs[1] = '{4'h3, 4'h4, 2'b01, 8'h07};
        vecs[2] = '{4'hF, 4'h5, 2'b10, 8'h0A};
        vecs[3] = '{4'h0, 4'h0, 2'b11, 8'hFF};
        vecs[4] = '{4'h5, 4'hA, 2'b11, 8'h5A};
        vecs[5] = '{4'h9, 4'h6, 2'b01, 8'h0F};

        reset_n = 1'b0;
        {bus_a.req0_valid, bus_a.req0_x, bus_a.req0_y, bus_a.req0_op} = 11'd0;
        {bus_a.req1_valid, bus_a.req1_x, bus_a.req1_y, bus_a.req1_op} = 11'd0;
        {bus_b.req0_valid, bus_b.req0_x, bus_b.req0_y, bus_b.req0_op} = 11'd0;
        {bus_b.req1_valid, bus_b.req1_x, bus_b.req1_y, bus_b.req1_op} = 11'd0;
        bus_a.rsp_ready = 1'b0;
        bus_b.rsp_ready = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        // Single request from requester 0, then its completion.
        bus_a.rsp_ready = 1'b1;
        bus_a.req0_valid = 1'b1; bus_a.req0_x = 4'hC; bus_a.req0_y = 4'hA; bus_a.req0_op = 2'b00;
        model_cycle(w);
        check("t1_z", {24'd0, bus_a.rsp_z}, 32'h08);
        check("t1_id", {31'd0, bus_a.rsp_id}, 32'd0);
        bus_a.req0_valid = 1'b0;
        model_cycle(w);
        check("t1_cnt0", {24'd0, bus_a.cnt0}, 32'd1);

        // Table of operations through requester 0, back to back.
        for (int i = 0; i < 6; i++) begin
            bus_a.req0_valid = 1'b1;
            bus_a.req0_x = vecs[i].x; bus_a.req0_y = vecs[i].y; bus_a.req0_op = vecs[i].op;
            model_cycle(w);
            check("tbl_z", {24'd0, bus_a.rsp_z}, {24'd0, vecs[i].z});
        end
        bus_a.req0_valid = 1'b0;
        model_cycle(w);

        // Both requesters contend every cycle: grants alternate from 0.
        do_reset();
        bus_a.rsp_ready = 1'b1;
        bus_a.req0_valid = 1'b1; bus_a.req0_x = 4'h3; bus_a.req0_y = 4'h4; bus_a.req0_op = 2'b01;
        bus_a.req1_valid = 1'b1; bus_a.req1_x = 4'hF; bus_a.req1_y = 4'h5; bus_a.req1_op = 2'b10;
        for (int i = 0; i < 4; i++) begin
            model_cycle(w);
            check("t2_id", {31'd0, bus_a.rsp_id}, i % 2);
            check("t2_z", {24'd0, bus_a.rsp_z}, (i % 2) ? 32'h0A : 32'h07);
        end

        // Stall while full: nothing granted, result held, then pass-through.
        bus_a.req0_valid = 1'b0;
        bus_a.req1_x = 4'hF; bus_a.req1_y = 4'h5; bus_a.req1_op = 2'b00;
        bus_a.rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            model_cycle(w);
            check("t3_hold_z", {24'd0, bus_a.rsp_z}, 32'h0A);
        end
        bus_a.rsp_ready = 1'b1;
        #2;
        check("t3_pass_ready", {31'd0, bus_a.req1_ready}, 32'd1);
        #1;
        model_cycle(w);
        check("t3_pass_z", {24'd0, bus_a.rsp_z}, 32'h05);
        bus_a.req1_valid = 1'b0;

        // Asynchronous reset while the buffer is full.
        bus_a.rsp_ready = 1'b0;
        bus_a.req0_valid = 1'b1; bus_a.req0_x = 4'hC; bus_a.req0_y = 4'hA; bus_a.req0_op = 2'b01;
        model_cycle(w);
        bus_a.req0_valid = 1'b0;
        model_cycle(w);
        #3;
        reset_n = 1'b0;
        #1;
        check_cleared("async");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
        bus_a.rsp_ready = 1'b1;
        bus_a.req0_valid = 1'b1;
        bus_a.req1_valid = 1'b1;
        #2;
        check("t5_first_contest", {30'd0, bus_a.req1_ready, bus_a.req0_ready}, 32'd1);
        #1;
        model_cycle(w);
        bus_a.req0_valid = 1'b0;
        bus_a.req1_valid = 1'b0;

        // Narrow counter wrap and fixed priority on the second instance.
        bus_b.rsp_ready = 1'b1;
        bus_b.req1_valid = 1'b1; bus_b.req1_x = 4'h3; bus_b.req1_y = 4'hC; bus_b.req1_op = 2'b01;
        for (int i = 0; i < 5; i++) begin
            #2;
            check("t6_req1_ready", {31'd0, bus_b.req1_ready}, 32'd1);
            @(posedge clk);
            #1;
            check("t6_z", {24'd0, bus_b.rsp_z}, 32'h0F);
        end
        bus_b.req1_valid = 1'b0;
        @(posedge clk);
        #1;
        check("t6_cnt1_wrap", {30'd0, bus_b.cnt1}, 32'd1);
        check("t6_cnt0", {30'd0, bus_b.cnt0}, 32'd0);
        bus_b.req0_valid = 1'b1;
        bus_b.req1_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #2;
            check("t6_prio", {30'd0, bus_b.req1_ready, bus_b.req0_ready}, 32'd1);
            @(posedge clk);
            #1;
        end
        bus_b.req0_valid = 1'b0;
        bus_b.req1_valid = 1'b0;

        // Randomized traffic honouring hold-until-ready on each requester.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            bus_a.rsp_ready = ($urandom_range(3) != 0);
            if (!bus_a.req0_valid) begin
                bus_a.req0_valid = 1'($urandom_range(1));
                bus_a.req0_x  = 4'($urandom);
                bus_a.req0_y  = 4'($urandom);
                bus_a.req0_op = 2'($urandom);
            end
            if (!bus_a.req1_valid) begin
                bus_a.req1_valid = 1'($urandom_range(1));
                bus_a.req1_x  = 4'($urandom);
                bus_a.req1_y  = 4'($urandom);
                bus_a.req1_op = 2'($urandom);
            end
            model_cycle(w);
            if (w == 0) bus_a.req0_valid = 1'b0;
            if (w == 1) bus_a.req1_valid = 1'b0;
        end
        bus_a.req0_valid = 1'b0;
        bus_a.req1_valid = 1'b0;
        bus_a.rsp_ready  = 1'b1;
        model_cycle(w);
        model_cycle(w);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
